// File: rtl/hub75_fb_loader.sv
// hub75_fb_loader: frame-buffer write sequencer for the HUB75 core.
// Takes a raster-ordered pixel stream (col fastest, then row, then bank),
// writes each pixel into the line buffer, stores every completed row and
// requests a frame swap once the last row of the last bank is stored.
//
// Handshake: a pixel transfers on a rising edge where in_valid && in_ready.
// in_ready is a registered function of the FSM state only (high exactly
// while in FILL) and never depends on in_valid; the source may raise or
// drop in_valid at will, and in_data/in_sof are consumed only on a transfer.
module hub75_fb_loader #(
  parameter int N_BANKS     = 2,
  parameter int N_ROWS      = 32,
  parameter int N_COLS      = 64,
  parameter int BITDEPTH    = 24,
  parameter int LOG_N_BANKS = $clog2(N_BANKS),
  parameter int LOG_N_ROWS  = $clog2(N_ROWS),
  parameter int LOG_N_COLS  = $clog2(N_COLS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BITDEPTH-1:0]    in_data,
  input  logic                   in_sof,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [BITDEPTH-1:0]    fbw_data,
  output logic [LOG_N_COLS-1:0]  fbw_col_addr,
  output logic                   fbw_wren,
  output logic [LOG_N_BANKS-1:0] fbw_bank_addr,
  output logic [LOG_N_ROWS-1:0]  fbw_row_addr,
  output logic                   fbw_row_swap,
  output logic                   fbw_row_store,
  input  logic                   fbw_row_rdy,
  output logic                   frame_swap,
  input  logic                   frame_rdy,
  input  logic                   ctrl_en,
  output logic                   stat_frame_done,
  output logic                   stat_resync,
  output logic                   stat_busy,
  output logic [2:0]             dbg_state
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FILL      = 3'd1;
  localparam logic [2:0] S_ROW_WAIT  = 3'd2;
  localparam logic [2:0] S_FRM_FLUSH = 3'd3;
  localparam logic [2:0] S_FRM_WAIT  = 3'd4;

  localparam logic [LOG_N_COLS-1:0]  COL_LAST  = LOG_N_COLS'(N_COLS - 1);
  localparam logic [LOG_N_ROWS-1:0]  ROW_LAST  = LOG_N_ROWS'(N_ROWS - 1);
  localparam logic [LOG_N_BANKS-1:0] BANK_LAST = LOG_N_BANKS'(N_BANKS - 1);
  localparam logic [1:0]             GUARD_END = 2'd2;

  logic [2:0]             r_state;
  logic [LOG_N_COLS-1:0]  r_col;
  logic [LOG_N_ROWS-1:0]  r_row;
  logic [LOG_N_BANKS-1:0] r_bank;
  logic [1:0]             r_guard;
  logic                   r_in_ready;
  logic [BITDEPTH-1:0]    r_fbw_data;
  logic [LOG_N_COLS-1:0]  r_fbw_col_addr;
  logic                   r_fbw_wren;
  logic [LOG_N_BANKS-1:0] r_fbw_bank_addr;
  logic [LOG_N_ROWS-1:0]  r_fbw_row_addr;
  logic                   r_row_swap;
  logic                   r_row_store;
  logic                   r_frame_swap;
  logic                   r_frame_done;
  logic                   r_resync;
  logic                   r_busy;

  logic [2:0] w_state_nxt;
  logic       w_hs;
  logic       w_at_origin;
  logic       w_resync;
  logic       w_last_col;
  logic       w_frame_end;

  // Next-state decode. Every pulse is issued while the FSM still sits in the
  // requesting state; the transition happens on the pulse cycle itself, so
  // each pulse costs exactly one extra cycle before the next state starts.
  always_comb begin
    w_hs        = (r_state == S_FILL) && r_in_ready && in_valid;
    w_at_origin = (r_col == '0) && (r_row == '0) && (r_bank == '0);
    w_resync    = w_hs && in_sof && !w_at_origin;
    w_last_col  = w_hs && !w_resync && (r_col == COL_LAST);
    w_frame_end = (r_row == ROW_LAST) && (r_bank == BANK_LAST);
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (ctrl_en) w_state_nxt = S_FILL;
      S_FILL:      if (w_last_col) w_state_nxt = S_ROW_WAIT;
      S_ROW_WAIT:  if (r_row_store) w_state_nxt = w_frame_end ? S_FRM_FLUSH : S_FILL;
      S_FRM_FLUSH: if (r_frame_swap) w_state_nxt = S_FRM_WAIT;
      S_FRM_WAIT:  if (r_frame_done) w_state_nxt = ctrl_en ? S_FILL : S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_col           <= '0;
      r_row           <= '0;
      r_bank          <= '0;
      r_guard         <= '0;
      r_in_ready      <= 1'b0;
      r_fbw_data      <= '0;
      r_fbw_col_addr  <= '0;
      r_fbw_wren      <= 1'b0;
      r_fbw_bank_addr <= '0;
      r_fbw_row_addr  <= '0;
      r_row_swap      <= 1'b0;
      r_row_store     <= 1'b0;
      r_frame_swap    <= 1'b0;
      r_frame_done    <= 1'b0;
      r_resync        <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_in_ready   <= (w_state_nxt == S_FILL);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_fbw_wren   <= 1'b0;
      r_row_swap   <= 1'b0;
      r_row_store  <= 1'b0;
      r_frame_swap <= 1'b0;
      r_frame_done <= 1'b0;
      r_resync     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ctrl_en) begin
            r_col  <= '0;
            r_row  <= '0;
            r_bank <= '0;
          end
        end
        S_FILL: begin
          if (w_hs) begin
            r_fbw_wren <= 1'b1;
            r_fbw_data <= in_data;
            if (w_resync) begin
              // Mid-frame start of frame: this pixel becomes col 0 of line 0
              // and the partial row is simply never stored.
              r_fbw_col_addr <= '0;
              r_col          <= LOG_N_COLS'(1);
              r_row          <= '0;
              r_bank         <= '0;
              r_resync       <= 1'b1;
            end else begin
              r_fbw_col_addr <= r_col;
              r_col          <= r_col + LOG_N_COLS'(1);
            end
          end
        end
        S_ROW_WAIT: begin
          if (r_row_store) begin
            r_row   <= r_row + LOG_N_ROWS'(1);
            r_guard <= '0;
            if (r_row == ROW_LAST) r_bank <= r_bank + LOG_N_BANKS'(1);
          end else if (fbw_row_rdy) begin
            r_row_swap      <= 1'b1;
            r_row_store     <= 1'b1;
            r_fbw_bank_addr <= r_bank;
            r_fbw_row_addr  <= r_row;
          end
        end
        S_FRM_FLUSH: begin
          // Two guard cycles let the last row store settle before its
          // fbw_row_rdy is trusted again.
          if (r_frame_swap) r_guard <= '0;
          else if (r_guard != GUARD_END) r_guard <= r_guard + 2'd1;
          else if (fbw_row_rdy) r_frame_swap <= 1'b1;
        end
        S_FRM_WAIT: begin
          // Two guard cycles so a stale frame_rdy from before the swap
          // request is not mistaken for completion.
          if (r_frame_done) r_guard <= '0;
          else if (r_guard != GUARD_END) r_guard <= r_guard + 2'd1;
          else if (frame_rdy) r_frame_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready        = r_in_ready;
  assign fbw_data        = r_fbw_data;
  assign fbw_col_addr    = r_fbw_col_addr;
  assign fbw_wren        = r_fbw_wren;
  assign fbw_bank_addr   = r_fbw_bank_addr;
  assign fbw_row_addr    = r_fbw_row_addr;
  assign fbw_row_swap    = r_row_swap;
  assign fbw_row_store   = r_row_store;
  assign frame_swap      = r_frame_swap;
  assign stat_frame_done = r_frame_done;
  assign stat_resync     = r_resync;
  assign stat_busy       = r_busy;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_hub75_fb_loader.sv
// Bench for hub75_fb_loader on a small 2x4x8 frame. A reference model
// computes expected writes and row stores from the pixel position alone;
// a negedge monitor compares DUT events against its queues.
module tb_hub75_fb_loader;

  localparam int N_BANKS   = 2;
  localparam int N_ROWS    = 4;
  localparam int N_COLS    = 8;
  localparam int BITDEPTH  = 24;
  localparam int LB        = $clog2(N_BANKS);
  localparam int LR        = $clog2(N_ROWS);
  localparam int LC        = $clog2(N_COLS);
  localparam int FRAME_PIX = N_BANKS * N_ROWS * N_COLS;
  localparam int W         = LC + BITDEPTH;
  localparam int WS        = LB + LR;

  // ---------------- clock / reset / DUT ----------------
  logic                clk;
  logic                rst;
  logic [BITDEPTH-1:0] in_data;
  logic                in_sof;
  logic                in_valid;
  logic                in_ready;
  logic [BITDEPTH-1:0] fbw_data;
  logic [LC-1:0]       fbw_col_addr;
  logic                fbw_wren;
  logic [LB-1:0]       fbw_bank_addr;
  logic [LR-1:0]       fbw_row_addr;
  logic                fbw_row_swap;
  logic                fbw_row_store;
  logic                fbw_row_rdy;
  logic                frame_swap;
  logic                frame_rdy;
  logic                ctrl_en;
  logic                stat_frame_done;
  logic                stat_resync;
  logic                stat_busy;
  logic [2:0]          dbg_state;

  hub75_fb_loader #(
    .N_BANKS(N_BANKS), .N_ROWS(N_ROWS), .N_COLS(N_COLS), .BITDEPTH(BITDEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sof(in_sof), .in_valid(in_valid), .in_ready(in_ready),
    .fbw_data(fbw_data), .fbw_col_addr(fbw_col_addr), .fbw_wren(fbw_wren),
    .fbw_bank_addr(fbw_bank_addr), .fbw_row_addr(fbw_row_addr),
    .fbw_row_swap(fbw_row_swap), .fbw_row_store(fbw_row_store),
    .fbw_row_rdy(fbw_row_rdy), .frame_swap(frame_swap), .frame_rdy(frame_rdy),
    .ctrl_en(ctrl_en), .stat_frame_done(stat_frame_done),
    .stat_resync(stat_resync), .stat_busy(stat_busy), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0]  exp_q[$];
  logic [WS-1:0] exp_st_q[$];
  int m_pos       = 0;
  int exp_frames  = 0;
  int exp_resync  = 0;

  int got_fswap  = 0;
  int got_done   = 0;
  int got_resync = 0;
  int last_store_cyc = 0;
  int fswap_cyc  = 0;
  int done_cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got event/timeout, want none (cycle %0d)", name, cyc);
  endtask

  // Reference model: position in frame decides column, line and store.
  task automatic model_accept(input logic [BITDEPTH-1:0] d, input bit s);
    int line;
    if (s && m_pos != 0) begin
      m_pos = 0;
      exp_resync++;
    end
    exp_q.push_back({LC'(m_pos % N_COLS), d});
    m_pos++;
    if (m_pos % N_COLS == 0) begin
      line = m_pos / N_COLS - 1;
      exp_st_q.push_back({LB'(line / N_ROWS), LR'(line % N_ROWS)});
    end
    if (m_pos == FRAME_PIX) begin
      m_pos = 0;
      exp_frames++;
    end
  endtask

  // ---------------- monitor ----------------
  logic [W-1:0]  mon_e;
  logic [WS-1:0] mon_s;
  logic prev_store = 1'b0;
  logic prev_fswap = 1'b0;
  logic prev_done  = 1'b0;
  logic prev_rsync = 1'b0;

  initial forever begin
    @(negedge clk);
    if (fbw_wren) begin
      if (exp_q.size() == 0) fail_now("wren_unexpected");
      else begin
        mon_e = exp_q.pop_front();
        check("wren_col_data", {fbw_col_addr, fbw_data}, mon_e);
      end
    end
    if (fbw_row_store || fbw_row_swap)
      check("swap_eq_store", fbw_row_swap, fbw_row_store);
    if (fbw_row_store) begin
      check("store_width", prev_store, 0);
      check("store_no_wren", fbw_wren, 0);
      if (exp_st_q.size() == 0) fail_now("store_unexpected");
      else begin
        mon_s = exp_st_q.pop_front();
        check("store_bank_row", {fbw_bank_addr, fbw_row_addr}, mon_s);
      end
      last_store_cyc = cyc;
    end
    if (frame_swap) begin
      check("fswap_width", prev_fswap, 0);
      got_fswap++;
      fswap_cyc = cyc;
    end
    if (stat_frame_done) begin
      check("done_width", prev_done, 0);
      got_done++;
      done_cyc = cyc;
    end
    if (stat_resync) begin
      check("resync_width", prev_rsync, 0);
      got_resync++;
    end
    prev_store = fbw_row_store;
    prev_fswap = frame_swap;
    prev_done  = stat_frame_done;
    prev_rsync = stat_resync;
  end

  // ---------------- driver tasks ----------------
  // Called 1ns after a negedge; applies inputs, returns 1ns after the next negedge.
  task automatic step(input bit v, input logic [BITDEPTH-1:0] d, input bit s);
    in_valid = v;
    in_data  = d;
    in_sof   = s;
    if (v && in_ready && !rst) model_accept(d, s);
    @(negedge clk);
    #1;
  endtask

  task automatic send_stream(input int n, input int sof_at, input bit rnd);
    int sent;
    int k;
    bit v;
    bit s;
    bit hs;
    bit exp_r;
    sent = 0;
    k = 0;
    while (sent < n && k < n * 12 + 200) begin
      v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rnd) begin
        fbw_row_rdy = ($urandom_range(0, 3) != 0);
        frame_rdy   = ($urandom_range(0, 3) != 0);
      end
      s = (sent == sof_at);
      hs = v && in_ready;
      exp_r = hs && s && (m_pos != 0);
      step(v, BITDEPTH'($urandom), s);
      if (hs) begin
        check("resync_pulse", stat_resync, exp_r);
        sent++;
      end
      k++;
    end
    if (sent < n) fail_now("send_timeout");
    in_valid = 1'b0;
    in_sof = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start;
    int k;
    start = got_done;
    k = 0;
    while (got_done == start && k < budget) begin
      step(0, '0, 0);
      k++;
    end
    if (got_done == start) fail_now("done_timeout");
  endtask

  task automatic wait_ready(input int budget);
    int k;
    k = 0;
    while (!in_ready && k < budget) begin
      step(0, '0, 0);
      k++;
    end
    if (!in_ready) fail_now("ready_timeout");
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_wren"}, fbw_wren, 0);
    check({tag, "_row_swap"}, fbw_row_swap, 0);
    check({tag, "_row_store"}, fbw_row_store, 0);
    check({tag, "_frame_swap"}, frame_swap, 0);
    check({tag, "_done"}, stat_frame_done, 0);
    check({tag, "_resync"}, stat_resync, 0);
    check({tag, "_busy"}, stat_busy, 0);
    check({tag, "_data"}, fbw_data, 0);
    check({tag, "_col"}, fbw_col_addr, 0);
    check({tag, "_bank"}, fbw_bank_addr, 0);
    check({tag, "_row"}, fbw_row_addr, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit en;
    bit v;
    bit s;
    bit rr;
    bit exp_rdy;
    bit exp_wren;
    int exp_col;
    bit exp_store;
  } vec_t;

  function automatic vec_t mkv(bit en, bit v, bit s, bit rr, bit rdy, bit wr, int col, bit st);
    vec_t t;
    t.en = en; t.v = v; t.s = s; t.rr = rr;
    t.exp_rdy = rdy; t.exp_wren = wr; t.exp_col = col; t.exp_store = st;
    return t;
  endfunction

  vec_t tbl[12];

  // ---------------- test sequence ----------------
  initial begin
    int start;
    int k;
    int sof_at;

    // First row from IDLE: enable, 8 pixels, turnaround, first pixel of row 1.
    tbl[0]  = mkv(1, 0, 0, 1, 1, 0, 0, 0);
    tbl[1]  = mkv(1, 1, 1, 1, 1, 1, 0, 0);
    tbl[2]  = mkv(1, 1, 0, 1, 1, 1, 1, 0);
    tbl[3]  = mkv(1, 1, 0, 1, 1, 1, 2, 0);
    tbl[4]  = mkv(1, 1, 0, 1, 1, 1, 3, 0);
    tbl[5]  = mkv(1, 1, 0, 1, 1, 1, 4, 0);
    tbl[6]  = mkv(1, 1, 0, 1, 1, 1, 5, 0);
    tbl[7]  = mkv(1, 1, 0, 1, 1, 1, 6, 0);
    tbl[8]  = mkv(1, 1, 0, 1, 0, 1, 7, 0);
    tbl[9]  = mkv(1, 0, 0, 1, 0, 0, 0, 1);
    tbl[10] = mkv(1, 0, 0, 1, 1, 0, 0, 0);
    tbl[11] = mkv(1, 1, 0, 1, 1, 1, 0, 0);

    rst = 1'b1; ctrl_en = 1'b0; in_valid = 1'b0; in_data = '0; in_sof = 1'b0;
    fbw_row_rdy = 1'b1; frame_rdy = 1'b1;
    @(negedge clk);
    #1;
    repeat (3) step(0, '0, 0);
    check_zero("reset");
    rst = 1'b0;
    step(0, '0, 0);
    check_zero("idle");

    // Table-driven first row and row turnaround.
    for (int i = 0; i < 12; i++) begin
      ctrl_en = tbl[i].en;
      fbw_row_rdy = tbl[i].rr;
      step(tbl[i].v, BITDEPTH'($urandom), tbl[i].s);
      check($sformatf("tbl%0d_ready", i), in_ready, tbl[i].exp_rdy);
      check($sformatf("tbl%0d_wren", i), fbw_wren, tbl[i].exp_wren);
      if (tbl[i].exp_wren) check($sformatf("tbl%0d_col", i), fbw_col_addr, tbl[i].exp_col);
      check($sformatf("tbl%0d_store", i), fbw_row_store, tbl[i].exp_store);
      check($sformatf("tbl%0d_busy", i), stat_busy, 1);
    end

    // Rest of frame 1 with everything ready: frame-end timing.
    send_stream(FRAME_PIX - 9, -1, 0);
    wait_done(100);
    check("fswap_after_store", fswap_cyc - last_store_cyc, 4);
    check("done_after_store", done_cyc - last_store_cyc, 8);
    check("ready_at_done", in_ready, 0);
    step(0, '0, 0);
    check("ready_after_done", in_ready, 1);
    check("frame1_fswaps", got_fswap, 1);
    check("frame1_dones", got_done, 1);
    check("frame1_wr_left", exp_q.size(), 0);
    check("frame1_st_left", exp_st_q.size(), 0);

    // Row store held off by fbw_row_rdy.
    fbw_row_rdy = 1'b0;
    send_stream(N_COLS, -1, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, BITDEPTH'($urandom), 0);
      check("rowrdy_low_ready", in_ready, 0);
      check("rowrdy_low_store", fbw_row_store, 0);
    end
    fbw_row_rdy = 1'b1;
    step(1, BITDEPTH'($urandom), 0);
    check("rowrdy_rise_store", fbw_row_store, 1);
    send_stream(N_COLS, -1, 0);

    // in_valid toggling: wren and column advance only on handshakes.
    wait_ready(20);
    for (int i = 0; i < 16; i++) begin
      step((i % 2) == 0, BITDEPTH'($urandom), 0);
      check("toggle_wren", fbw_wren, (i % 2) == 0);
      if ((i % 2) == 0) check("toggle_col", fbw_col_addr, i / 2);
    end
    send_stream(FRAME_PIX - 3 * N_COLS, -1, 0);
    wait_done(100);
    check("frame2_dones", got_done, 2);

    // Resync on the 20th pixel (bank 0, row 2, col 3).
    send_stream(19 + FRAME_PIX, 19, 0);
    check("resync_count", got_resync, 1);
    wait_done(100);
    check("frame3_dones", got_done, 3);

    // frame_rdy held low after frame_swap; ctrl_en dropped mid-frame.
    frame_rdy = 1'b0;
    send_stream(10, -1, 0);
    ctrl_en = 1'b0;
    send_stream(FRAME_PIX - 10, -1, 0);
    start = got_fswap;
    k = 0;
    while (got_fswap == start && k < 100) begin
      step(0, '0, 0);
      k++;
    end
    if (got_fswap == start) fail_now("fswap_timeout");
    for (int i = 0; i < 50; i++) begin
      step(1, BITDEPTH'($urandom), 0);
      check("frdy_low_done", stat_frame_done, 0);
      check("frdy_low_ready", in_ready, 0);
    end
    frame_rdy = 1'b1;
    step(0, '0, 0);
    check("frdy_rise_done", stat_frame_done, 1);
    step(0, '0, 0);
    check("idle_after_frame_busy", stat_busy, 0);
    check("idle_after_frame_ready", in_ready, 0);
    ctrl_en = 1'b1;
    step(0, '0, 0);
    check("reenable_ready", in_ready, 1);
    check("reenable_busy", stat_busy, 1);
    check("frame4_dones", got_done, 4);

    // Reset mid-row at col 5: everything cleared, partial row never stored.
    send_stream(5, -1, 0);
    rst = 1'b1;
    step(1, BITDEPTH'($urandom), 0);
    check_zero("rst_mid");
    check("rst_wr_drained", exp_q.size(), 0);
    m_pos = 0;
    exp_q.delete();
    exp_st_q.delete();
    rst = 1'b0;
    step(0, '0, 0);
    check("rst_restart_ready", in_ready, 1);
    send_stream(FRAME_PIX, -1, 0);
    wait_done(100);
    check("frame5_dones", got_done, 5);

    // Randomized frames: random valid, rdy inputs, data and resync point.
    for (int f = 0; f < 4; f++) begin
      sof_at = ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(1, FRAME_PIX - 1));
      send_stream(sof_at + FRAME_PIX, sof_at, 1);
      fbw_row_rdy = 1'b1;
      frame_rdy = 1'b1;
      wait_done(200);
      step(0, '0, 0);
    end

    check("final_wr_left", exp_q.size(), 0);
    check("final_st_left", exp_st_q.size(), 0);
    check("final_dones", got_done, exp_frames);
    check("final_fswaps", got_fswap, exp_frames);
    check("final_resyncs", got_resync, exp_resync);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hub75_fb_loader.md
# hub75_fb_loader

Frame-buffer write sequencer for the HUB75 core. Accepts a raster-ordered pixel stream over a valid/ready handshake and drives the core's frame-buffer write port:
- column writes into the line buffer;
- row swap and store;
- frame swap.

It sits between a pixel source (video pipeline, DMA, SPI bridge) and the `fbw_*` / `frame_*` ports of the core. One frame is exactly N_BANKS × N_ROWS × N_COLS pixels.

## Interface
- N_BANKS, 2, parallel readout banks (≥2, power of 2)
- N_ROWS, 32, rows per bank (power of 2)
- N_COLS, 64, columns (power of 2)
- BITDEPTH, 24, bits per pixel
- LOG_N_BANKS / LOG_N_ROWS / LOG_N_COLS, auto, $clog2 of the above

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_data  in  BITDEPTH  pixel
- in_sof  in  1  marks first pixel of a frame
- in_valid  in  1  pixel valid
- in_ready  out  1  pixel accepted when in_valid & in_ready
- fbw_data  out  BITDEPTH  line-buffer write data
- fbw_col_addr  out  LOG_N_COLS  line-buffer column
- fbw_wren  out  1  line-buffer write strobe
- fbw_bank_addr  out  LOG_N_BANKS  bank of row being stored
- fbw_row_addr  out  LOG_N_ROWS  row being stored
- fbw_row_swap  out  1  one-cycle line-buffer swap pulse
- fbw_row_store  out  1  one-cycle row store pulse
- fbw_row_rdy  in  1  frame buffer can accept a row store
- frame_swap  out  1  one-cycle frame swap request
- frame_rdy  in  1  no frame swap pending
- ctrl_en  in  1  enable loading
- stat_frame_done  out  1  one-cycle pulse, frame swap completed
- stat_resync  out  1  one-cycle pulse, mid-frame in_sof realigned counters
- stat_busy  out  1  high whenever state ≠ IDLE

## Operation
- Pixel order: col fastest, then row, then bank (panel line = bank·N_ROWS + row).
- Counters col/row/bank wrap at N_COLS-1 / N_ROWS-1 / N_BANKS-1.
- Every output is registered.

States:
- IDLE: in_ready=0. If ctrl_en, clear counters → FILL.
- FILL: in_ready=1. On handshake, the next cycle carries fbw_wren=1, fbw_data=in_data, fbw_col_addr=col; col++. Handshake at col=N_COLS-1 → ROW_WAIT.
- ROW_WAIT: in_ready=0. When fbw_row_rdy=1, the next cycle pulses fbw_row_swap and fbw_row_store together, with fbw_bank_addr/fbw_row_addr = current bank/row (held until the next store). Then:
  - advance row (bank on row wrap);
  - if the stored row was row N_ROWS-1 of bank N_BANKS-1 → FRM_FLUSH, else → FILL.
- FRM_FLUSH: 2-cycle guard (fbw_row_rdy ignored), then wait fbw_row_rdy=1 → pulse frame_swap next cycle → FRM_WAIT.
- FRM_WAIT: 2-cycle guard (frame_rdy ignored), then wait frame_rdy=1 → pulse stat_frame_done; → FILL if ctrl_en, else IDLE.

Resync (in_sof):
- A FILL handshake with in_sof=1 while (col,row,bank)≠(0,0,0) writes that pixel at col 0, sets counters to col=1/row 0/bank 0, and pulses stat_resync.
- The partial row is discarded (never stored). Rows already stored this frame stay in the back buffer and are overwritten later.
- in_sof=1 at position 0 is normal.
- in_sof=0 at position 0 is accepted (no resync).

ctrl_en:
- Sampled only in IDLE and at the FRM_WAIT exit.
- Deasserting mid-frame does not stop the frame; rst is the only abort.

## Timing
- Reset (synchronous): state IDLE, counters 0. All outputs 0:
  - in_ready, fbw_wren, fbw_row_swap, fbw_row_store, frame_swap, stat_*;
  - fbw_data, fbw_col_addr, fbw_bank_addr, fbw_row_addr.
- rst mid-frame: next cycle IDLE. Any pulse in flight is cancelled; no partial store.
- Write latency: handshake at t → fbw_wren at t+1. Back-to-back handshakes give back-to-back wren (1 pixel/clk).
- Last column handshake at t: ROW_WAIT from t+1, earliest swap/store pulse at t+2. A store never coincides with a wren of the same row.
- Row turnaround with fbw_row_rdy held high: in_ready low exactly 2 cycles (t+1, t+2); FILL resumes at t+3.
- fbw_row_rdy low: ROW_WAIT holds indefinitely, in_ready stays 0.
- Frame end with both rdy inputs high: store pulse at s, frame_swap at s+4, stat_frame_done at s+8, in_ready high at s+9.
- Pulses (swap, store, frame_swap, stat_*) are exactly one cycle wide.

## Test plan
Parameters for all scenarios: N_BANKS=2, N_ROWS=4, N_COLS=8.
- Full frame, in_valid and both rdy held high → 64 wren with col 0..7 repeating; 8 store pulses with (bank,row) = (0,0)…(0,3),(1,0)…(1,3); 1 frame_swap 4 cycles after the last store; stat_frame_done 4 cycles later.
- fbw_row_rdy low for 10 cycles after row 0 is filled → no store and in_ready=0 for those cycles; store pulse the cycle after rdy rises; row 1 data then accepted.
- in_valid toggling 1,0,1,0 → wren only the cycle after each handshake; fbw_col_addr increments only on handshake.
- in_sof=1 on the 20th pixel (bank 0, row 2, col 3) → stat_resync pulse; that pixel written at col 0; next store is (0,0); 64 more pixels complete the frame.
- frame_rdy held low 50 cycles after frame_swap → in_ready stays 0; stat_frame_done the cycle after frame_rdy rises.
- rst asserted mid-row (col 5) → next cycle all outputs 0, stat_busy=0; with ctrl_en=1, loading restarts at (0,0,0) with no store of the partial row.
